// File: rtl/cpu_defs_pkg.sv
// Shared P7 CPU definitions: instruction encodings, exception codes and
// the memory-map constants used by the fetch stage.
package cpu_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] EXC_NONE   = 5'd0;
  localparam logic [4:0] EXC_ADEL   = 5'd4;
  localparam logic [4:0] EXC_ADES   = 5'd5;
  localparam logic [4:0] EXC_RI     = 5'd10;
  localparam logic [4:0] EXC_OV     = 5'd12;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6ffc;

  // How an instruction sitting in D can steer the next fetch.
  typedef enum logic [1:0] {
    CT_NONE,
    CT_BRANCH,
    CT_JUMP,
    CT_JREG
  } ctrl_kind_t;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Decodes the instruction in D and produces the delay-slot flag plus the
// candidate next PC (control-transfer target, or pc+4 when not redirecting).
module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic        d_cmp,
  input  logic [31:0] d_rs,
  input  logic [31:0] pc,
  output logic        is_ctrl,
  output logic        redirect,
  output logic [31:0] target
);

  ctrl_kind_t  kind;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] d_pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign opcode        = d_instr[31:26];
  assign funct         = d_instr[5:0];
  assign d_pc_plus4    = d_pc + 32'd4;
  assign branch_target = d_pc_plus4 + branch_offset(d_instr[15:0]);
  assign jump_target   = {d_pc_plus4[31:28], d_instr[25:0], 2'b00};

  always_comb begin
    kind = CT_NONE;
    case (opcode)
      OP_BEQ, OP_BNE: kind = CT_BRANCH;
      OP_J, OP_JAL:   kind = CT_JUMP;
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) kind = CT_JREG;
      end
      default:        kind = CT_NONE;
    endcase
  end

  // bne's inverted sense is already folded into d_cmp by the compare unit.
  always_comb begin
    is_ctrl  = (kind != CT_NONE);
    redirect = 1'b0;
    target   = pc + 32'd4;
    case (kind)
      CT_BRANCH: begin
        if (d_cmp) begin
          redirect = 1'b1;
          target   = branch_target;
        end
      end
      CT_JUMP: begin
        redirect = 1'b1;
        target   = jump_target;
      end
      CT_JREG: begin
        redirect = 1'b1;
        target   = d_rs;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// F stage of the P7 MIPS pipeline: PC register, next-PC priority selection
// and fetch address-error detection.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
  parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
  parameter logic [31:0] IM_LO      = cpu_defs::IM_LO,
  parameter logic [31:0] IM_HI      = cpu_defs::IM_HI,
  parameter logic [4:0]  EXC_ADEL   = cpu_defs::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fd_stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic        d_cmp,
  input  logic [31:0] d_rs,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_bd,
  output logic [4:0]  f_exc
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] seq_target;
  logic        is_ctrl;
  logic        redirect;
  logic        adel;

  npc_calc u_npc_calc (
    .d_instr  (d_instr),
    .d_pc     (d_pc),
    .d_cmp    (d_cmp),
    .d_rs     (d_rs),
    .pc       (pc),
    .is_ctrl  (is_ctrl),
    .redirect (redirect),
    .target   (seq_target)
  );

  // Exception entry and eret must win over a hazard stall.
  always_comb begin
    next_pc = seq_target;
    if (req)           next_pc = HANDLER_PC;
    else if (eret)     next_pc = epc;
    else if (fd_stall) next_pc = pc;
    else if (redirect) next_pc = seq_target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  assign adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

  assign i_inst_addr = pc;
  assign f_pc        = pc;
  assign f_bd        = is_ctrl;
  assign f_exc       = adel ? EXC_ADEL : cpu_defs::EXC_NONE;
  assign f_instr     = adel ? 32'h0000_0000 : i_inst_rdata;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F stage of the P7 MIPS pipeline: owns the PC register, drives the instruction-memory address, and produces f_instr/f_pc/f_bd/f_exc for the F/D pipeline register.
- Resolves next-PC from the instruction currently in D (branches/jumps), stall, exception entry (req) and eret.
- Detects fetch address errors (AdEL) and substitutes a nop.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6ffc, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, ExcCode for fetch address error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- fd_stall  in  1  hold PC (from hazard unit); same signal that holds F/D.
- req  in  1  exception/interrupt taken (from CP0); redirect to HANDLER_PC.
- eret  in  1  eret in D/M (per CP0 convention); redirect to epc.
- epc  in  32  return address from CP0.
- d_instr  in  32  instruction currently in D.
- d_pc  in  32  PC of D instruction.
- d_cmp  in  1  D-stage branch compare result (1 = condition true).
- d_rs  in  32  forwarded rs value in D (jr/jalr target).
- i_inst_addr  out  32  instruction-memory address.
- i_inst_rdata  in  32  instruction-memory read data (combinational).
- f_pc  out  32  PC of fetched instruction.
- f_instr  out  32  fetched instruction (0 on AdEL).
- f_bd  out  1  fetched instruction is in a delay slot.
- f_exc  out  5  ExcCode for F (0 = none).

Behaviour:
- State: 32-bit pc register only. Async reset (reset==0) -> pc = RESET_PC immediately, regardless of clk.
- i_inst_addr = f_pc = pc (combinational). Under reset: RESET_PC.
- Next-pc priority, evaluated each posedge:
  1. req -> HANDLER_PC.
  2. eret -> epc.
  3. fd_stall -> pc (hold).
  4. D is a control-transfer instruction -> target (below).
  5. Otherwise -> pc+4 (wraps mod 2^32).
- req and eret override fd_stall. req with eret in the same cycle -> HANDLER_PC.
- D decode (opcode = d_instr[31:26], funct = d_instr[5:0]):
  - beq 000100: taken iff d_cmp. Target = d_pc+4 + (sign_ext(imm16)<<2). Not taken -> pc+4.
  - bne 000101: taken iff d_cmp. The D compare unit already applies the ne sense; this block treats d_cmp==1 as taken.
  - j 000010 / jal 000011: target = {d_pc_plus4[31:28], d_instr[25:0], 2'b00}.
  - jr (op 0, funct 001000) / jalr (op 0, funct 001001): target = d_rs, unmodified, no alignment masking.
  - Any other opcode: not control transfer.
- f_bd = 1 iff d_instr decodes to any of the six above, taken or not. d_instr == 0 -> f_bd = 0.
- AdEL when pc[1:0] != 0 or pc < IM_LO or pc > IM_HI (unsigned).
  - On AdEL: f_exc = EXC_ADEL, f_instr = 32'h0. f_pc and f_bd are still reported.
  - Otherwise: f_exc = 0, f_instr = i_inst_rdata.
- Misaligned target is loaded into pc as-is; the fault is raised in the cycle it is fetched.
- Reset deasserting mid-stall: fetch resumes at RESET_PC. No other state needs clearing.

Decomposition:
- Shared package (cpu_defs): opcode/funct constants (BEQ, BNE, J, JAL, SPECIAL, JR, JALR), ExcCode constants (EXC_ADEL etc.), RESET_PC, HANDLER_PC, IM_LO/IM_HI.
- One combinational sub-module, npc_calc: inputs d_instr, d_pc, d_cmp, d_rs, pc; outputs is_ctrl (→ f_bd), redirect, target.
- fetch_stage holds the pc register, priority mux and AdEL check.

Test Plan:
- Reset low for 2 cycles, release, d_instr=0 -> pc 3000, 3004, 3008; f_exc=0, f_bd=0.
- D=beq imm=16'h0003, d_pc=3000, d_cmp=1, pc=3004 -> f_bd=1 at 3004; next pc = 3010.
- Same with d_cmp=0 -> next pc = 3008, f_bd=1.
- fd_stall=1 for 3 cycles at pc=3020 -> pc stays 3020. Assert req during stall -> next pc = 4180. eret with epc=3040 -> next pc = 3040.
- D=jr, d_rs=32'h3002 -> next pc = 3002, f_exc=4, f_instr=0. d_rs=32'h7000 -> f_exc=4. d_rs=32'h6ffc -> f_exc=0.
- Drive reset low asynchronously between edges with pc=3100 -> pc reads 3000 before the next posedge.
